// File: rtl/inst_fetch_fifo.sv
// rtl/inst_fetch_fifo.sv - sequential instruction prefetch with in-flight tracking and DEPTH-entry FIFO
// Define FETCH_PERF_EN to add the fetch_cnt_o / flush_cnt_o performance counters.
module inst_fetch_fifo #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter int                MEM_LAT  = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              mem_ce_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              inst_valid_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  input  logic              inst_ready_i
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       fetch_cnt_o,
  output logic [31:0]       flush_cnt_o
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;

  logic [ADDR_W-1:0] fetch_pc;
  logic              slot_vld  [MEM_LAT];
  logic [ADDR_W-1:0] slot_pc   [MEM_LAT];
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [ADDR_W-1:0] fifo_pc   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  occ_cnt;
  logic [CNT_W-1:0]  infl_cnt;
  logic [SUM_W-1:0]  credit_used;
  logic              issue;
  logic              push;
  logic              pop;

  // Every outstanding request holds a FIFO slot, so responses can never overflow.
  assign credit_used  = {1'b0, occ_cnt} + {1'b0, infl_cnt};
  assign issue        = rst && !redirect_i && (credit_used < SUM_W'(DEPTH));
  assign push         = slot_vld[MEM_LAT-1] && !redirect_i;
  assign inst_valid_o = (occ_cnt != '0) && !redirect_i;
  assign pop          = inst_valid_o && inst_ready_i;

  assign mem_ce_o   = issue;
  assign mem_addr_o = fetch_pc;
  assign inst_o     = fifo_data[rd_ptr];
  assign inst_pc_o  = fifo_pc[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_i) begin
      fetch_pc <= redirect_pc_i;
    end else if (issue) begin
      fetch_pc <= fetch_pc + ADDR_W'(4);
    end
  end

  // Slot MEM_LAT-1 lines up with the cycle in which mem_data_i carries its word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MEM_LAT; i++) begin
        slot_vld[i] <= 1'b0;
        slot_pc[i]  <= '0;
      end
      infl_cnt <= '0;
    end else if (redirect_i) begin
      for (int i = 0; i < MEM_LAT; i++) begin
        slot_vld[i] <= 1'b0;
      end
      infl_cnt <= '0;
    end else begin
      slot_vld[0] <= issue;
      slot_pc[0]  <= fetch_pc;
      for (int i = 1; i < MEM_LAT; i++) begin
        slot_vld[i] <= slot_vld[i-1];
        slot_pc[i]  <= slot_pc[i-1];
      end
      infl_cnt <= infl_cnt + CNT_W'(issue) - CNT_W'(slot_vld[MEM_LAT-1]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_pc[i]   <= '0;
      end
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ_cnt <= '0;
    end else if (redirect_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ_cnt <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= mem_data_i;
        fifo_pc[wr_ptr]   <= slot_pc[MEM_LAT-1];
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      occ_cnt <= occ_cnt + CNT_W'(push) - CNT_W'(pop);
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (pop) begin
        fetch_cnt_o <= fetch_cnt_o + 32'd1;
      end
      if (redirect_i) begin
        flush_cnt_o <= flush_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_fifo.sv
// tb/tb_inst_fetch_fifo.sv - bench for inst_fetch_fifo: vector table, directed corners, randomized model run
module tb_inst_fetch_fifo;

  localparam int DEPTH   = 4;
  localparam int MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        mem_ce_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_i = '0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i = 1'b0;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_o;
  logic [31:0] flush_cnt_o;
`endif

  inst_fetch_fifo #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .DEPTH    (DEPTH),
    .MEM_LAT  (MEM_LAT),
    .RESET_PC (32'h0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .mem_ce_o      (mem_ce_o),
    .mem_addr_o    (mem_addr_o),
    .mem_data_i    (mem_data_i),
    .inst_valid_o  (inst_valid_o),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o),
    .inst_ready_i  (inst_ready_i)
`ifdef FETCH_PERF_EN
    ,
    .fetch_cnt_o   (fetch_cnt_o),
    .flush_cnt_o   (flush_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    int          due;
  } pend_t;

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
  } ent_t;

  typedef struct {
    bit          rst_first;
    bit          rdy;
    bit          rd;
    logic [31:0] rpc;
    bit          e_ce;
    logic [31:0] e_addr;
    bit          e_v;
    logic [31:0] e_pc;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  pend_t       mpend[$];
  ent_t        mfifo[$];
  logic [31:0] m_pc;
  logic [31:0] m_fetch;
  logic [31:0] m_flush;

  logic        hist_ce   [64];
  logic [31:0] hist_addr [64];

  logic        s_ce;
  logic [31:0] s_addr;
  logic        s_v;
  logic [31:0] s_pc;
  logic [31:0] s_inst;
  logic [31:0] s_fetch;
  logic [31:0] s_flush;

  vec_t        tbl[$];

  function automatic logic [31:0] hash(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void add(input bit rf, input bit rdy, input bit rd, input logic [31:0] rpc,
                              input bit ce, input logic [31:0] addr, input bit v, input logic [31:0] pc);
    vec_t t;
    t.rst_first = rf; t.rdy = rdy; t.rd = rd; t.rpc = rpc;
    t.e_ce = ce; t.e_addr = addr; t.e_v = v; t.e_pc = pc;
    tbl.push_back(t);
  endfunction

  task automatic model_reset();
    mfifo.delete();
    mpend.delete();
    m_pc    = 32'h0;
    m_fetch = '0;
    m_flush = '0;
    for (int i = 0; i < 64; i++) begin
      hist_ce[i]   = 1'b0;
      hist_addr[i] = '0;
    end
  endtask

  // Asserts reset mid-cycle, checks the asynchronous clear, releases just after a rising edge.
  task automatic do_reset();
    rst = 1'b0;
    redirect_i = 1'b0;
    redirect_pc_i = '0;
    inst_ready_i = 1'b0;
    #1;
    chk("rst_mem_ce", 32'(mem_ce_o), 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_inst_valid", 32'(inst_valid_o), 32'd0);
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_inst_pc", inst_pc_o, 32'h0);
`ifdef FETCH_PERF_EN
    chk("rst_fetch_cnt", fetch_cnt_o, 32'd0);
    chk("rst_flush_cnt", flush_cnt_o, 32'd0);
`endif
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // One clock cycle: drive inputs and memory data, sample at the falling edge, compare, advance the model.
  task automatic run_cycle(input logic rd, input logic [31:0] rpc, input logic rdy);
    int    hi;
    logic  ev;
    logic  ece;
    ent_t  e;
    pend_t p;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    inst_ready_i  = rdy;
    hi = (cyc - MEM_LAT) & 63;
    if (cyc >= MEM_LAT && hist_ce[hi]) mem_data_i = hash(hist_addr[hi]);
    else mem_data_i = $urandom;
    @(negedge clk);
    s_ce = mem_ce_o; s_addr = mem_addr_o; s_v = inst_valid_o; s_pc = inst_pc_o; s_inst = inst_o;
`ifdef FETCH_PERF_EN
    s_fetch = fetch_cnt_o; s_flush = flush_cnt_o;
`else
    s_fetch = '0; s_flush = '0;
`endif
    ev  = (mfifo.size() != 0) && !rd;
    ece = !rd && (int'(mfifo.size() + mpend.size()) < DEPTH);
    chk("model_mem_ce", 32'(s_ce), 32'(ece));
    chk("model_mem_addr", s_addr, m_pc);
    chk("model_inst_valid", 32'(s_v), 32'(ev));
    if (ev) begin
      chk("model_inst_pc", s_pc, mfifo[0].pc);
      chk("model_inst", s_inst, mfifo[0].data);
    end
`ifdef FETCH_PERF_EN
    chk("model_fetch_cnt", s_fetch, m_fetch);
    chk("model_flush_cnt", s_flush, m_flush);
`endif
    hist_ce[cyc & 63]   = s_ce;
    hist_addr[cyc & 63] = s_addr;
    if (rd) begin
      mfifo.delete();
      mpend.delete();
      m_pc = rpc;
      m_flush = m_flush + 32'd1;
    end else begin
      if (ev && rdy) begin
        void'(mfifo.pop_front());
        m_fetch = m_fetch + 32'd1;
      end
      if (mpend.size() != 0 && mpend[0].due == cyc) begin
        p = mpend.pop_front();
        e.pc = p.pc;
        e.data = hash(p.pc);
        mfifo.push_back(e);
      end
      if (ece) begin
        p.pc = m_pc;
        p.due = cyc + MEM_LAT;
        mpend.push_back(p);
        m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        rd;
    logic        prev_rd;
    logic        rdy;
    logic [31:0] rpc;

    // Ready held high from reset: addresses 0,4,8.. and first valid four cycles in.
    add(1,1,0,0, 1,32'd0, 0,0);
    add(0,1,0,0, 1,32'd4, 0,0);
    add(0,1,0,0, 1,32'd8, 0,0);
    add(0,1,0,0, 1,32'd12,1,32'd0);
    add(0,1,0,0, 1,32'd16,1,32'd4);
    add(0,1,0,0, 1,32'd20,1,32'd8);
    // Ready low from reset: four requests, stall, then ordered drain and resume at 16.
    add(1,0,0,0, 1,32'd0, 0,0);
    add(0,0,0,0, 1,32'd4, 0,0);
    add(0,0,0,0, 1,32'd8, 0,0);
    add(0,0,0,0, 1,32'd12,1,32'd0);
    add(0,0,0,0, 0,32'd16,1,32'd0);
    add(0,0,0,0, 0,32'd16,1,32'd0);
    add(0,0,0,0, 0,32'd16,1,32'd0);
    add(0,1,0,0, 0,32'd16,1,32'd0);
    add(0,1,0,0, 1,32'd16,1,32'd4);
    add(0,1,0,0, 1,32'd20,1,32'd8);
    add(0,1,0,0, 1,32'd24,1,32'd12);
    add(0,1,0,0, 1,32'd28,1,32'd16);
    // Redirect to 0x100 with two buffered and two in flight.
    add(1,0,0,0, 1,32'd0, 0,0);
    add(0,0,0,0, 1,32'd4, 0,0);
    add(0,0,0,0, 1,32'd8, 0,0);
    add(0,0,0,0, 1,32'd12,1,32'd0);
    add(0,0,1,32'h100, 0,32'd16,0,0);
    add(0,1,0,0, 1,32'h100,0,0);
    add(0,1,0,0, 1,32'h104,0,0);
    add(0,1,0,0, 1,32'h108,0,0);
    add(0,1,0,0, 1,32'h10C,1,32'h100);
    add(0,1,0,0, 1,32'h110,1,32'h104);
    // Redirect while a response returns with ready high, target at the top of the address space.
    add(1,1,0,0, 1,32'd0, 0,0);
    add(0,1,0,0, 1,32'd4, 0,0);
    add(0,1,0,0, 1,32'd8, 0,0);
    add(0,1,1,32'hFFFFFFFC, 0,32'd12,0,0);
    add(0,1,0,0, 1,32'hFFFFFFFC,0,0);
    add(0,1,0,0, 1,32'h0, 0,0);
    add(0,1,0,0, 1,32'h4, 0,0);
    add(0,1,0,0, 1,32'h8, 1,32'hFFFFFFFC);
    add(0,1,0,0, 1,32'hC, 1,32'h0);
    // Back-to-back redirects: the second target wins.
    add(1,1,0,0, 1,32'd0, 0,0);
    add(0,1,1,32'h200, 0,32'd4, 0,0);
    add(0,1,1,32'h300, 0,32'h200,0,0);
    add(0,1,0,0, 1,32'h300,0,0);
    add(0,1,0,0, 1,32'h304,0,0);
    add(0,1,0,0, 1,32'h308,0,0);
    add(0,1,0,0, 1,32'h30C,1,32'h300);

    #2;
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst_first) do_reset();
      run_cycle(tbl[i].rd, tbl[i].rpc, tbl[i].rdy);
      chk($sformatf("tbl%0d_mem_ce", i), 32'(s_ce), 32'(tbl[i].e_ce));
      chk($sformatf("tbl%0d_mem_addr", i), s_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_inst_valid", i), 32'(s_v), 32'(tbl[i].e_v));
      if (tbl[i].e_v) begin
        chk($sformatf("tbl%0d_inst_pc", i), s_pc, tbl[i].e_pc);
        chk($sformatf("tbl%0d_inst", i), s_inst, hash(tbl[i].e_pc));
      end
    end

`ifdef FETCH_PERF_EN
    do_reset();
    for (int i = 0; i < 13; i++) run_cycle(1'b0, 32'h0, 1'b1);
    run_cycle(1'b1, 32'h40, 1'b1);
    run_cycle(1'b1, 32'h40, 1'b1);
    run_cycle(1'b0, 32'h0, 1'b1);
    chk("perf_fetch_cnt_10", s_fetch, 32'd10);
    chk("perf_flush_cnt_2", s_flush, 32'd2);
`endif

    do_reset();
    prev_rd = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        do_reset();
        prev_rd = 1'b0;
      end
      rd = prev_rd ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 99) < 4);
      case ($urandom_range(0, 3))
        0:       rpc = $urandom;
        1:       rpc = $urandom & 32'hFFFFFFFC;
        2:       rpc = 32'hFFFFFFF0 | ($urandom & 32'hC);
        default: rpc = $urandom & 32'h00000FFC;
      endcase
      if (((i / 150) % 2) == 0) rdy = ($urandom_range(0, 9) < 8);
      else rdy = ($urandom_range(0, 9) < 2);
      run_cycle(rd, rpc, rdy);
      prev_rd = rd;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
